// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: timed Moore controller for a two-street intersection
// with sensor-extended green and an inserted pedestrian walk phase.
module traffic_phase_ctrl #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int PED_T     = 3,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ta,
  input  logic       tb,
  input  logic       ped_req,
  output logic [1:0] la,
  output logic [1:0] lb,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_pending
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5,
    PED   = 3'd6,
    BAD   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] C_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] C_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] C_YEL  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] C_AR   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] C_PED  = CNT_W'(PED_T - 1);

  localparam logic [1:0] L_GRN = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_RED = 2'b10;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ped;
  logic             r_next_b;
  logic             w_chg;
  logic             w_enter_ped;
  logic             w_a_go;
  logic             w_b_go;

  // green exit: hard limit, or minimum served and no demand to keep it
  assign w_a_go = (r_cnt == C_GMAX) ||
                  ((r_cnt >= C_GMIN) && (!ta || r_ped));
  assign w_b_go = (r_cnt == C_GMAX) ||
                  ((r_cnt >= C_GMIN) && (!tb || r_ped));

  assign w_chg       = (w_next != r_state);
  assign w_enter_ped = w_chg && (w_next == PED);

  // state register, phase timer, pedestrian latch and walk-return flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= A_GRN;
      r_cnt    <= '0;
      r_ped    <= 1'b0;
      r_next_b <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_chg)
        r_cnt <= '0;
      else if (tick)
        r_cnt <= r_cnt + 1'b1;
      if (ped_req && (r_state != PED))
        r_ped <= 1'b1;
      else if (w_enter_ped)
        r_ped <= 1'b0;
      if (w_enter_ped)
        r_next_b <= (r_state == AR_AB);
    end
  end

  // next-state decision, evaluated only on tick edges
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      A_GRN: if (tick && w_a_go) w_next = A_YEL;
      A_YEL: if (tick && r_cnt == C_YEL) w_next = AR_AB;
      AR_AB: if (tick && r_cnt == C_AR)
               w_next = r_ped ? PED : B_GRN;
      B_GRN: if (tick && w_b_go) w_next = B_YEL;
      B_YEL: if (tick && r_cnt == C_YEL) w_next = AR_BA;
      AR_BA: if (tick && r_cnt == C_AR)
               w_next = r_ped ? PED : A_GRN;
      PED:   if (tick && r_cnt == C_PED)
               w_next = r_next_b ? B_GRN : A_GRN;
      default: w_next = A_GRN;
    endcase
  end

  // Moore lamp decode from state only
  always_comb begin
    la   = L_RED;
    lb   = L_RED;
    walk = 1'b0;
    unique case (r_state)
      A_GRN: la = L_GRN;
      A_YEL: la = L_YEL;
      B_GRN: lb = L_GRN;
      B_YEL: lb = L_YEL;
      PED:   walk = 1'b1;
      default: ;
    endcase
  end

  assign phase       = r_state;
  assign ped_pending = r_ped;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed checks of phase sequencing, green
// extension, pedestrian insertion, tick gating and async reset.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       ta = 1'b0;
  logic       tb = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] la;
  logic [1:0] lb;
  logic       walk;
  logic [2:0] phase;
  logic       ped_pending;

  int total = 0;
  int bad = 0;

  // phase sequence with no demand: 0x4 1x2 2x1 3x4 4x2 5x1
  logic [2:0] seq [14] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2,
                           3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5};

  traffic_phase_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .ta(ta), .tb(tb),
    .ped_req(ped_req), .la(la), .lb(lb), .walk(walk),
    .phase(phase), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_la(input logic [2:0] p);
    case (p)
      3'd0: return 2'b00;
      3'd1: return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] exp_lb(input logic [2:0] p);
    case (p)
      3'd3: return 2'b00;
      3'd4: return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic chk_all(input string tag, input logic [2:0] p);
    chk({tag, ".phase"}, {1'b0, phase}, {1'b0, p});
    chk({tag, ".la"}, {2'b0, la}, {2'b0, exp_la(p)});
    chk({tag, ".lb"}, {2'b0, lb}, {2'b0, exp_lb(p)});
    chk({tag, ".walk"}, {3'b0, walk}, {3'b0, p == 3'd6});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // async reset visible before any clock edge
    #1;
    chk_all("rst0", 3'd0);
    chk("rst0.ped", {3'b0, ped_pending}, 4'd0);

    // free run, no demand
    tick = 1'b1;
    do_reset();
    for (int i = 0; i < 28; i++) begin
      chk_all($sformatf("run%0d", i), seq[i % 14]);
      @(negedge clk);
    end

    // street A demand held: green runs to its maximum
    ta = 1'b1;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      chk_all($sformatf("max%0d", i),
              (i < 8) ? 3'd0 : (i < 10) ? 3'd1 : 3'd2);
      @(negedge clk);
    end

    // single pedestrian pulse cuts the extended green short
    do_reset();
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    chk("pp.set", {3'b0, ped_pending}, 4'd1);
    for (int i = 1; i < 18; i++) begin
      logic [2:0] e;
      e = (i < 4)  ? 3'd0 : (i < 6)  ? 3'd1 : (i < 7)  ? 3'd2 :
          (i < 10) ? 3'd6 : (i < 14) ? 3'd3 : (i < 16) ? 3'd4 :
          (i < 17) ? 3'd5 : 3'd0;
      chk_all($sformatf("ped%0d", i), e);
      if (i >= 7 && i < 10)
        chk($sformatf("ped%0d.pend", i), {3'b0, ped_pending}, 4'd0);
      @(negedge clk);
    end

    // request held across the walk entry edge re-arms a second walk
    do_reset();
    ped_req = 1'b1;
    for (int i = 0; i < 21; i++) begin
      logic [2:0] e;
      e = (i < 4)  ? 3'd0 : (i < 6)  ? 3'd1 : (i < 7)  ? 3'd2 :
          (i < 10) ? 3'd6 : (i < 14) ? 3'd3 : (i < 16) ? 3'd4 :
          (i < 17) ? 3'd5 : (i < 20) ? 3'd6 : 3'd0;
      chk_all($sformatf("hold%0d", i), e);
      if (i == 7)
        chk("hold.pend_kept", {3'b0, ped_pending}, 4'd1);
      if (i == 17)
        chk("hold.pend_clr", {3'b0, ped_pending}, 4'd0);
      if (i == 7) ped_req = 1'b0;
      @(negedge clk);
    end
    ta = 1'b0;

    // tick every fifth cycle: phases stretch by five clocks
    tick = 1'b0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      chk_all($sformatf("slow%0d", i), seq[(i / 5) % 14]);
      tick = ((i % 5) == 4);
      @(negedge clk);
    end

    // reset mid B_YEL with a pending request
    tick = 1'b1;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      ped_req = (i == 9);
      @(negedge clk);
    end
    ped_req = 1'b0;
    chk_all("mid.byel", 3'd4);
    chk("mid.pend", {3'b0, ped_pending}, 4'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("mid.rst", 3'd0);
    chk("mid.rst.pend", {3'b0, ped_pending}, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_all($sformatf("after%0d", i), (i < 4) ? 3'd0 : 3'd1);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Timed Moore controller for a two-street intersection (street A, street B). It sequences green, yellow and all-red phases using a tick-driven phase timer, extends green while the traffic sensor reports cars, and inserts a pedestrian walk phase on request. It drives the light-encoding outputs consumed by the lamp drivers and sits between the sensor/button synchronizers and the lamp outputs.

## Interface
- GREEN_MIN, 4, minimum green duration in ticks (>=1)
- GREEN_MAX, 8, maximum green duration in ticks (>=GREEN_MIN)
- YELLOW_T, 2, yellow duration in ticks (>=1)
- ALLRED_T, 1, all-red clearance in ticks (>=1)
- PED_T, 3, pedestrian walk duration in ticks (>=1)
- CNT_W, 4, timer width; every duration parameter <= 2^CNT_W
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- tick  in  1  single-cycle timebase strobe; timer and transitions advance only on tick=1
- ta  in  1  car present on street A (synchronous, pre-synchronized)
- tb  in  1  car present on street B
- ped_req  in  1  pedestrian button, level or pulse, sampled every clk
- la  out  2  street A light: 00 green, 01 yellow, 10 red
- lb  out  2  street B light, same encoding
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state code
- ped_pending  out  1  pedestrian request latched, not yet served

## Operation
- States / phase code: A_GRN 0, A_YEL 1, AR_AB 2, B_GRN 3, B_YEL 4, AR_BA 5, PED 6; code 7 unused, decodes to A_GRN next.
- Moore outputs decoded from state only: A_GRN la=00 lb=10; A_YEL la=01 lb=10; AR_AB/AR_BA/PED la=10 lb=10; B_GRN la=10 lb=00; B_YEL la=10 lb=01; walk=1 only in PED; unused code: both red, walk=0.
- Timer cnt (CNT_W bits): cleared on every state change; on tick with no transition, cnt<=cnt+1.
- A_GRN, on tick: cnt==GREEN_MAX-1 -> A_YEL; else cnt>=GREEN_MIN-1 and (ta==0 or ped_pending) -> A_YEL; else stay.
- B_GRN: identical with tb, -> B_YEL.
- A_YEL/B_YEL, on tick: cnt==YELLOW_T-1 -> AR_AB/AR_BA.
- AR_AB, on tick: cnt==ALLRED_T-1 -> PED if ped_pending else B_GRN. AR_BA: same, else A_GRN.
- next_b flag: set entering PED from AR_AB, cleared entering PED from AR_BA. PED, on tick: cnt==PED_T-1 -> B_GRN if next_b else A_GRN.
- ped_pending: set by ped_req==1 in any cycle with state!=PED; cleared on the edge entering PED; if ped_req=1 on that same edge, set wins (stays 1). ped_req while in PED is ignored.
- ta/tb never cause a transition alone before GREEN_MIN; GREEN_MAX bounds starvation of the other street.

## Timing
- reset (async): state A_GRN, cnt 0, ped_pending 0, next_b 0; la=00 lb=10 walk=0 phase=0 immediately, independent of clk.
- Reset mid-operation from any state: same values, no completion of current phase.
- All transitions on rising clk with tick=1; tick=0 freezes state, cnt, outputs (ped_pending still latches).
- Outputs change on the same edge as state (no extra latency); phase entered on edge k lasts exactly N ticks for fixed-duration phases.
- Green duration: GREEN_MIN..GREEN_MAX ticks; sensor/ped sampled on the deciding tick edge.
- No 01->00 or 00->10 direct transition on either street; both streets never non-red simultaneously.

## Test plan
- Reset, ta=tb=0, tick every cycle -> phase sequence 0(4),1(2),2(1),3(4),4(2),5(1), repeat; period 14 cycles; walk=0 throughout.
- ta=1, tb=0 held -> A_GRN lasts exactly 8 ticks (GREEN_MAX), then la=01 for 2 ticks.
- ped_req pulse on cycle 1 with ta=1 -> ped_pending=1; A_GRN ends at 4 ticks, A_YEL 2, AR_AB 1, PED 3 with walk=1, ped_pending=0 in PED, then B_GRN.
- ped_req held high across PED entry edge -> ped_pending stays 1; second PED after next AR_BA, then A_GRN (next_b=0).
- tick=1 every 5th cycle -> each phase lasts ticks x5 clk; state/cnt constant between ticks.
- reset asserted mid B_YEL (lb=01) -> same cycle la=00 lb=10 phase=0 ped_pending=0; after release, normal 4-tick A_GRN.
